// File: rtl/minhash_pkg.sv
// Shared constants and types for the MinHash top-K sort controller.
// The sorter it drives keeps the smallest signatures; all-ones marks an empty slot.
package minhash_pkg;

    localparam int SIGNATURE_WIDTH = 32;
    localparam int INDEX_WIDTH     = 10;
    localparam int NUM_COMPARATORS = 8;
    localparam int LOG_COMPARATORS = 3;
    localparam int DRAIN_CYCLES    = 8;

    localparam logic [SIGNATURE_WIDTH-1:0] SENTINEL_SIG = '1;
    localparam logic [INDEX_WIDTH-1:0]     SENTINEL_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUTPUT
    } ctrl_state_e;

    typedef logic [NUM_COMPARATORS-1:0][INDEX_WIDTH-1:0] index_array_t;

endpackage

// File: rtl/minhash_sort_ctrl_topk_serializer.sv
// Captures the sorter's top-K index array and presents it one rank per beat,
// rank 0 first, under a valid/ready handshake.
module topk_serializer
    import minhash_pkg::*;
#(
    parameter int INDEX_WIDTH     = 10,
    parameter int NUM_COMPARATORS = 8,
    parameter int LOG_COMPARATORS = 3
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           load,
    input  logic                                           flush,
    input  logic [LOG_COMPARATORS-1:0]                     last_rank_in,
    input  logic [NUM_COMPARATORS-1:0][INDEX_WIDTH-1:0]    indices_in,
    input  logic                                           out_ready,
    output logic                                           out_valid,
    output logic [INDEX_WIDTH-1:0]                         out_index,
    output logic [LOG_COMPARATORS-1:0]                     out_rank,
    output logic                                           out_last,
    output logic                                           last_fire
);

    logic [NUM_COMPARATORS-1:0][INDEX_WIDTH-1:0] snap_q, snap_d;
    logic [LOG_COMPARATORS-1:0]                  rank_q, rank_d;
    logic [LOG_COMPARATORS-1:0]                  last_rank_q, last_rank_d;
    logic                                        active_q, active_d;
    logic                                        fire;

    assign fire = active_q && out_ready;

    always_comb begin
        snap_d      = snap_q;
        rank_d      = rank_q;
        last_rank_d = last_rank_q;
        active_d    = active_q;
        if (flush) begin
            active_d = 1'b0;
            rank_d   = '0;
        end else if (load) begin
            snap_d      = indices_in;
            last_rank_d = last_rank_in;
            rank_d      = '0;
            active_d    = 1'b1;
        end else if (fire) begin
            if (rank_q == last_rank_q) begin
                active_d = 1'b0;
                rank_d   = '0;
            end else begin
                rank_d = rank_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the snapshot is only K small words, so it is reset with the
            // rest of the state; out_index is then a defined 0 straight out of reset.
            snap_q      <= '0;
            rank_q      <= '0;
            last_rank_q <= '0;
            active_q    <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            rank_q      <= rank_d;
            last_rank_q <= last_rank_d;
            active_q    <= active_d;
        end
    end

    assign out_valid = active_q;
    assign out_index = snap_q[rank_q];
    assign out_rank  = rank_q;
    assign out_last  = active_q && (rank_q == last_rank_q);
    assign last_fire = fire && out_last;

endmodule

// File: rtl/minhash_sort_ctrl.sv
// Sequences one sorter over a set of MinHash signatures: clear, feed with
// generated indices, drain the insertion pipeline, then stream out the top-K.
module minhash_sort_ctrl #(
    parameter int SIGNATURE_WIDTH = minhash_pkg::SIGNATURE_WIDTH,
    parameter int INDEX_WIDTH     = minhash_pkg::INDEX_WIDTH,
    parameter int NUM_COMPARATORS = minhash_pkg::NUM_COMPARATORS,
    parameter int LOG_COMPARATORS = minhash_pkg::LOG_COMPARATORS,
    parameter int DRAIN_CYCLES    = minhash_pkg::DRAIN_CYCLES
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [INDEX_WIDTH-1:0]                      set_len,
    input  logic                                        abort,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [SIGNATURE_WIDTH-1:0]                  in_signature,
    output logic                                        sort_clear,
    output logic [SIGNATURE_WIDTH-1:0]                  sort_signature,
    output logic [INDEX_WIDTH-1:0]                      sort_index,
    input  logic [NUM_COMPARATORS-1:0][INDEX_WIDTH-1:0] sort_indices,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [INDEX_WIDTH-1:0]                      out_index,
    output logic [LOG_COMPARATORS-1:0]                  out_rank,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        done
);

    import minhash_pkg::*;

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e                state_q, state_d;
    logic [INDEX_WIDTH-1:0]     set_len_q, set_len_d;
    logic [INDEX_WIDTH-1:0]     elem_cnt_q, elem_cnt_d;
    logic [DRAIN_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic                       sort_clear_q, sort_clear_d;
    logic [SIGNATURE_WIDTH-1:0] sort_sig_q, sort_sig_d;
    logic [INDEX_WIDTH-1:0]     sort_idx_q, sort_idx_d;
    logic                       zero_done_q, zero_done_d;
    logic                       snap_load;
    logic                       flush;
    logic                       last_fire;
    logic [LOG_COMPARATORS-1:0] last_rank;

    assign flush = abort && (state_q != IDLE);

    // n_out = min(set_len, K); the serializer only needs the final rank.
    always_comb begin
        if (set_len_q >= INDEX_WIDTH'(NUM_COMPARATORS)) begin
            last_rank = LOG_COMPARATORS'(NUM_COMPARATORS - 1);
        end else begin
            last_rank = LOG_COMPARATORS'(set_len_q - 1'b1);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        set_len_d    = set_len_q;
        elem_cnt_d   = elem_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        sort_clear_d = 1'b0;
        sort_sig_d   = {SIGNATURE_WIDTH{1'b1}};
        sort_idx_d   = {INDEX_WIDTH{1'b1}};
        zero_done_d  = 1'b0;
        snap_load    = 1'b0;
        if (flush) begin
            state_d      = IDLE;
            sort_clear_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (set_len != '0) begin
                            set_len_d    = set_len;
                            sort_clear_d = 1'b1;
                            state_d      = CLEAR;
                        end else begin
                            zero_done_d = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    elem_cnt_d = '0;
                    state_d    = FEED;
                end
                FEED: begin
                    if (in_valid) begin
                        sort_sig_d = in_signature;
                        sort_idx_d = elem_cnt_q;
                        elem_cnt_d = elem_cnt_q + 1'b1;
                        if (elem_cnt_q == set_len_q - 1'b1) begin
                            drain_cnt_d = '0;
                            state_d     = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        snap_load = 1'b1;
                        state_d   = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (last_fire) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            set_len_q    <= '0;
            elem_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            sort_clear_q <= 1'b0;
            sort_sig_q   <= {SIGNATURE_WIDTH{1'b1}};
            sort_idx_q   <= '0;
            zero_done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples its _d value from before this edge, independent of order.
            state_q      <= state_d;
            set_len_q    <= set_len_d;
            elem_cnt_q   <= elem_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            sort_clear_q <= sort_clear_d;
            sort_sig_q   <= sort_sig_d;
            sort_idx_q   <= sort_idx_d;
            zero_done_q  <= zero_done_d;
        end
    end

    topk_serializer #(
        .INDEX_WIDTH     (INDEX_WIDTH),
        .NUM_COMPARATORS (NUM_COMPARATORS),
        .LOG_COMPARATORS (LOG_COMPARATORS)
    ) u_serializer (
        .clock        (clock),
        .reset        (reset),
        .load         (snap_load),
        .flush        (flush),
        .last_rank_in (last_rank),
        .indices_in   (sort_indices),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_index    (out_index),
        .out_rank     (out_rank),
        .out_last     (out_last),
        .last_fire    (last_fire)
    );

    assign in_ready       = (state_q == FEED);
    assign busy           = (state_q != IDLE);
    assign done           = zero_done_q || (last_fire && !abort);
    assign sort_clear     = sort_clear_q;
    assign sort_signature = sort_sig_q;
    assign sort_index     = sort_idx_q;

endmodule

// File: tb/tb_minhash_sort_ctrl.sv
// Self-checking bench: a behavioural top-K sorter sits on the sorter ports and
// expected ranks come from counting smaller signatures in the stimulus list.
module tb_minhash_sort_ctrl;

    import minhash_pkg::*;

    localparam int SW   = SIGNATURE_WIDTH;
    localparam int IW   = INDEX_WIDTH;
    localparam int K    = NUM_COMPARATORS;
    localparam int LW   = LOG_COMPARATORS;
    // An element on the sorter ports in cycle t+1 shows in sort_indices in
    // cycle t+DRAIN_CYCLES, i.e. exactly on the controller's last drain cycle.
    localparam int PIPE = DRAIN_CYCLES - 2;

    logic                clock;
    logic                reset;
    logic                start;
    logic [IW-1:0]       set_len;
    logic                abort;
    logic                in_valid;
    logic                in_ready;
    logic [SW-1:0]       in_signature;
    logic                sort_clear;
    logic [SW-1:0]       sort_signature;
    logic [IW-1:0]       sort_index;
    index_array_t        sort_indices;
    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       out_index;
    logic [LW-1:0]       out_rank;
    logic                out_last;
    logic                busy;
    logic                done;

    minhash_sort_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .set_len        (set_len),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_signature   (in_signature),
        .sort_clear     (sort_clear),
        .sort_signature (sort_signature),
        .sort_index     (sort_index),
        .sort_indices   (sort_indices),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_rank       (out_rank),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Behavioural sorter: sorted list of K (sig, idx) pairs, strict less-than insertion.
    logic [K-1:0][SW-1:0]    m_sig, m_sig_n;
    index_array_t            m_idx, m_idx_n;
    logic [PIPE-1:0][SW-1:0] p_sig;
    logic [PIPE-1:0][IW-1:0] p_idx;
    int                      m_pos;

    always_comb begin
        m_sig_n = m_sig;
        m_idx_n = m_idx;
        m_pos   = K;
        for (int i = K - 1; i >= 0; i--) if (p_sig[PIPE-1] < m_sig[i]) m_pos = i;
        for (int i = 1; i < K; i++) begin
            if (i > m_pos) begin
                m_sig_n[i] = m_sig[i-1];
                m_idx_n[i] = m_idx[i-1];
            end
        end
        if (m_pos < K) begin
            m_sig_n[m_pos] = p_sig[PIPE-1];
            m_idx_n[m_pos] = p_idx[PIPE-1];
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset || sort_clear) begin
            m_sig <= '1;
            m_idx <= '1;
            p_sig <= '1;
            p_idx <= '1;
        end else begin
            m_sig <= m_sig_n;
            m_idx <= m_idx_n;
            p_sig <= {p_sig[PIPE-2:0], sort_signature};
            p_idx <= {p_idx[PIPE-2:0], sort_index};
        end
    end

    assign sort_indices = m_idx;

    int n_checks = 0;
    int n_passed = 0;
    int n_failed = 0;

    logic [SW-1:0] sigs [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Element index holding a given rank: count strictly smaller signatures,
    // with equal signatures ordered by arrival.
    function automatic int ref_index(input int rank);
        int smaller;
        for (int i = 0; i < sigs.size(); i++) begin
            smaller = 0;
            for (int j = 0; j < sigs.size(); j++)
                if (sigs[j] < sigs[i] || (sigs[j] == sigs[i] && j < i)) smaller++;
            if (smaller == rank) return i;
        end
        return -1;
    endfunction

    task automatic load_fixed9();
        sigs = '{32'h10, 32'h08, 32'h20, 32'h05, 32'h15, 32'h25, 32'h35, 32'h45, 32'h55};
    endtask

    task automatic load_random(input int len, input int max_val);
        sigs.delete();
        for (int k = 0; k < len; k++) sigs.push_back(SW'($urandom_range(0, max_val)));
    endtask

    // valid_mode: 0 back-to-back, 1 toggle, 2 random
    task automatic begin_set(input int valid_mode);
        int len, i, cyc;
        logic v, prev_acc;
        logic [SW-1:0] prev_sig;
        logic [IW-1:0] prev_idx;
        len = sigs.size();
        out_ready = 1'b0;
        start = 1'b1;
        set_len = IW'(len);
        @(negedge clock);
        start = 1'b0;
        check("clear_pulse", sort_clear, 1);
        check("busy_clear", busy, 1);
        cyc = 0;
        while (!in_ready && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check("feed_entry", in_ready, 1);
        check("clear_single", sort_clear, 0);
        prev_acc = 1'b0;
        prev_sig = SENTINEL_SIG;
        prev_idx = SENTINEL_IDX;
        i = 0;
        cyc = 0;
        while (i < len && cyc < len * 8 + 100) begin
            check("sort_sig", sort_signature, prev_acc ? prev_sig : SENTINEL_SIG);
            check("sort_idx", sort_index, prev_acc ? prev_idx : SENTINEL_IDX);
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_signature = v ? sigs[i] : SW'($urandom);
            prev_acc = v && in_ready;
            if (prev_acc) begin
                prev_sig = sigs[i];
                prev_idx = IW'(i);
                i++;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_count", i, len);
        check("sort_sig_last", sort_signature, prev_sig);
        check("sort_idx_last", sort_index, prev_idx);
        check("ready_drop", in_ready, 0);
    endtask

    // ready_mode: 0 always ready, 1 random; stall_rank holds ready low 5 cycles at that rank
    task automatic collect(input int ready_mode, input int stall_rank);
        int len, n, r, cyc, stall;
        logic rdy;
        int exp_idx [K];
        len = sigs.size();
        n = (len < K) ? len : K;
        for (int k = 0; k < n; k++) exp_idx[k] = ref_index(k);
        r = 0;
        stall = 0;
        cyc = 0;
        while (r < n && cyc < 400) begin
            if (out_valid) begin
                check("out_rank", out_rank, r);
                check("out_index", out_index, exp_idx[r]);
                check("out_last", out_last, r == n - 1);
                if (r == stall_rank && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                out_ready = rdy;
                #1;
                check("done_beat", done, rdy && (r == n - 1));
                if (rdy) r++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                check("done_early", done, 0);
            end
            @(negedge clock);
            cyc++;
        end
        check("result_count", r, n);
        if (stall_rank >= 0) check("stall_cycles", stall, 5);
        check("busy_after", busy, 0);
        check("valid_after", out_valid, 0);
        check("done_after", done, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_len = '0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_signature = '0;
        out_ready = 1'b0;
        #1 reset = 1'b0;
        #2;
        check("rst_sort_sig", sort_signature, SENTINEL_SIG);
        check("rst_sort_idx", sort_index, 0);
        check("rst_sort_clear", sort_clear, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_rank", out_rank, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Nine elements back-to-back with a five-cycle stall at rank 2.
        load_fixed9();
        begin_set(0);
        collect(0, 2);

        // Same set with in_valid toggling.
        load_fixed9();
        begin_set(1);
        collect(0, -1);

        // Short set: fewer elements than K.
        sigs = '{32'h30, 32'h10, 32'h20};
        begin_set(0);
        collect(0, -1);

        // Abort after four accepted beats.
        load_fixed9();
        out_ready = 1'b0;
        start = 1'b1;
        set_len = IW'(9);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_signature = sigs[k];
            @(negedge clock);
        end
        in_valid = 1'b0;
        abort = 1'b1;
        #1 check("abort_no_done", done, 0);
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_clear", sort_clear, 1);
        check("abort_done", done, 0);
        @(negedge clock);
        check("abort_clear_once", sort_clear, 0);
        check("abort_done_later", done, 0);

        // Full set after the abort reproduces the first result sequence.
        begin_set(0);
        collect(0, -1);

        // Zero-length set.
        start = 1'b1;
        set_len = '0;
        @(negedge clock);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clock);
        check("zero_done_once", done, 0);
        check("zero_out_valid", out_valid, 0);

        // Randomised sets, one with a narrow value range to force ties.
        for (int it = 0; it < 4; it++) begin
            load_random($urandom_range(1, 20), (it == 1) ? 15 : 32'h7fff_ffff);
            begin_set(2);
            collect(1, -1);
        end

        // Largest representable set length.
        load_random((1 << IW) - 1, 32'hffff_fffe);
        begin_set(0);
        collect(0, -1);

        // Asynchronous reset during OUTPUT.
        sigs = '{32'h30, 32'h10, 32'h20};
        begin_set(0);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clock);
        check("pre_reset_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_sort_sig", sort_signature, SENTINEL_SIG);
        check("arst_sort_idx", sort_index, 0);
        check("arst_out_index", out_index, 0);
        check("arst_out_rank", out_rank, 0);
        check("arst_out_last", out_last, 0);
        check("arst_done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_idle", busy, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/minhash_sort_ctrl.md
Name: minhash_sort_ctrl

Overview:
- Sequences one `sorter_v2` instance over a set of MinHash signatures.
- Accepts a stream of signatures from the hash units over valid/ready. Clears the sorter at set start, feeds it one signature per cycle with an auto-generated element index, and drains the sorter pipeline.
- Snapshots the top-K indices (smallest signatures) and emits them serially, rank 0 first, to the signature-store writer.

Parameters:
- SIGNATURE_WIDTH, 32, signature width.
- INDEX_WIDTH, 10, element index width; also the width of the set length.
- NUM_COMPARATORS, 8, K = sorter depth = number of results.
- LOG_COMPARATORS, 3, clog2(NUM_COMPARATORS); rank width.
- DRAIN_CYCLES, 8, idle cycles fed after the last element before the snapshot (equals the sorter insertion latency).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin a set; sampled only in IDLE.
- set_len  in  INDEX_WIDTH  number of elements in the set; latched on start.
- abort  in  1  abandon the current set.
- in_valid  in  1  signature beat valid.
- in_ready  out  1  controller accepts a beat.
- in_signature  in  SIGNATURE_WIDTH  signature value.
- sort_clear  out  1  synchronous clear to the sorter.
- sort_signature  out  SIGNATURE_WIDTH  to sorter signature_in.
- sort_index  out  INDEX_WIDTH  to sorter index_in.
- sort_indices  in  NUM_COMPARATORS x INDEX_WIDTH  sorter result array; entry 0 holds the smallest signature.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- out_index  out  INDEX_WIDTH  element index for the current rank.
- out_rank  out  LOG_COMPARATORS  rank of the current beat.
- out_last  out  1  final result beat of the set.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a set completes.

Behaviour:
- Reset values: all outputs are 0, except sort_signature, which resets to all-ones (SENTINEL). State resets to IDLE, counters to 0.
- Registered outputs: all sort_* outputs are registered. An element accepted in cycle t reaches the sorter ports in cycle t+1.
- Sentinel:
  - Any cycle without an accepted beat drives sort_signature = all-ones and sort_index = all-ones.
  - The sorter compares with strict less-than, so a sentinel never displaces real data.
  - An all-ones input signature is reserved; hash units never produce it.
- IDLE:
  - in_ready = 0.
  - start with set_len != 0: latch set_len, go to CLEAR.
  - start with set_len == 0: pulse done next cycle, stay in IDLE, emit no results.
- CLEAR: sort_clear = 1 for exactly one cycle, elem_cnt := 0, then go to FEED.
- FEED:
  - in_ready = 1.
  - On in_valid && in_ready: sort_signature := in_signature, sort_index := elem_cnt, elem_cnt increments.
  - Bubbles (no in_valid) feed the sentinel.
  - Accepting the beat with elem_cnt == set_len-1 moves to DRAIN; in_ready drops in the following cycle.
- DRAIN: feed sentinels for DRAIN_CYCLES cycles. On the last drain cycle, copy sort_indices into the snapshot registers, set n_out = min(set_len, NUM_COMPARATORS), then go to OUTPUT.
- OUTPUT:
  - out_valid = 1, out_index = snap[rank], out_rank = rank, starting at rank 0.
  - rank advances on out_valid && out_ready; out_index and out_rank hold stable while stalled.
  - out_last = 1 when rank == n_out-1.
  - Handshake on out_last: done pulses in the same cycle as that handshake, then go to IDLE.
- start outside IDLE is ignored.
- abort (any non-IDLE state):
  - Next state is IDLE; in_ready and out_valid are 0 in the next cycle.
  - sort_clear pulses for one cycle; done is not pulsed.
  - abort takes priority over a simultaneous handshake.
- Reset asserted mid-operation: immediate return to reset values. The sorter is reset by its own reset connection.
- set_len == 2^INDEX_WIDTH-1: the counter reaches the maximum without wrap. Index all-ones is never produced for a real element because that value would require set_len = 2^INDEX_WIDTH, which is not representable.

Decomposition:
- Package minhash_pkg:
  - SIGNATURE_WIDTH, INDEX_WIDTH, NUM_COMPARATORS, LOG_COMPARATORS.
  - SENTINEL_SIG = all-ones.
  - typedef enum ctrl_state_e {IDLE, CLEAR, FEED, DRAIN, OUTPUT}.
  - typedef index array type.
- One sub-module, topk_serializer: snapshot registers, rank counter, and the out_valid/out_ready/out_last logic.

Test Plan:
- start, set_len=9; signatures 0x10,0x08,0x20,0x05,0x15,0x25,0x35,0x45,0x55 back-to-back -> sort_index 0..8; outputs ranked 3,1,0,4,2,5,6,7; out_last on rank 7; one done pulse.
- Same set with in_valid toggling 1/0 each cycle -> sentinels fed in the gaps; identical result sequence.
- set_len=3; signatures 0x30,0x10,0x20 -> exactly 3 beats with indices 1,2,0; out_last on rank 2.
- out_ready held 0 for 5 cycles at rank 2 of the first scenario -> out_index=0 and out_rank=2 stable throughout; no beat lost or duplicated.
- abort after the 4th accepted beat -> IDLE next cycle, sort_clear pulses once, no done. A new start with set_len=9 then reproduces the first scenario's results.
- start with set_len=0 -> done pulse, no out_valid. Async reset asserted during OUTPUT -> all outputs 0 and sort_signature all-ones immediately.
